fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; the transmitting end of the IF→DE valid/allowin interface.
- Generates the next PC (sequential, branch, jump, exception, eret) and drives a synchronous instruction SRAM with 1-cycle read latency.
- Owns the IF/DE pipeline register. Inst_IF_DE, PC_IF_DE and the other *_IF_DE outputs describe the instruction currently held in decode.
- Buffers SRAM read data while decode stalls.

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC selection, synchronous instruction SRAM request,
// stall buffering of read data and the IF/DE pipeline register. Optional counters: FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        decode_allowin,
  input  logic        decode_stage_valid,
  input  logic        is_j_or_br_DE,
  input  logic [1:0]  PCSrc,
  input  logic        JSrc,
  input  logic [31:0] J_target_DE,
  input  logic [31:0] JR_target_DE,
  input  logic [31:0] Br_target_DE,
  input  logic        ex_int_handle,
  input  logic        eret_handle,
  input  logic [31:0] epc,
  output logic        fe_to_de_valid,
  output logic [31:0] Inst_IF_DE,
  output logic [31:0] PC_IF_DE,
  output logic [31:0] PC_add_4_IF_DE,
  output logic        PC_AdEL_IF_DE,
  output logic        DSI_IF_DE,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  logic [31:0] fs_pc_q, fs_pc_d;
  logic        fs_valid_q, fs_valid_d;
  logic        fs_adel_q, fs_adel_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic        de_valid_q, de_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        adel_q, adel_d;
  logic        dsi_q, dsi_d;

  logic        fs_allowin, flush, fetch_go, transfer, nextpc_adel;
  logic [31:0] nextpc, fs_inst;

  assign fs_allowin  = !fs_valid_q || decode_allowin;
  assign flush       = ex_int_handle || eret_handle;
  // A redirect must issue its fetch even while decode is stalled.
  assign fetch_go    = fs_allowin || flush;
  assign transfer    = fs_valid_q && decode_allowin && !flush;
  assign nextpc_adel = (nextpc[1:0] != 2'b00);
  assign fs_inst     = fs_adel_q ? '0 : (buf_valid_q ? inst_buf_q : inst_sram_rdata);

  always_comb begin
    nextpc = fs_pc_q + 32'd4;
    if (ex_int_handle)         nextpc = EXC_VECTOR;
    else if (eret_handle)      nextpc = epc;
    else if (PCSrc == 2'b01)   nextpc = Br_target_DE;
    else if (PCSrc == 2'b10)   nextpc = JSrc ? JR_target_DE : J_target_DE;
  end

  assign inst_sram_en   = fetch_go && !rst && !nextpc_adel;
  assign inst_sram_addr = nextpc;

  always_comb begin
    fs_pc_d     = fs_pc_q;
    fs_valid_d  = fs_valid_q;
    fs_adel_d   = fs_adel_q;
    inst_buf_d  = inst_buf_q;
    buf_valid_d = buf_valid_q;
    de_valid_d  = de_valid_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    pc4_d       = pc4_q;
    adel_d      = adel_q;
    dsi_d       = dsi_q;

    if (fetch_go) begin
      fs_pc_d    = nextpc;
      fs_valid_d = 1'b1;
      fs_adel_d  = nextpc_adel;
    end

    if (flush) begin
      buf_valid_d = 1'b0;
      de_valid_d  = 1'b0;
    end else if (transfer) begin
      buf_valid_d = 1'b0;
      de_valid_d  = 1'b1;
      inst_d      = fs_inst;
      pc_d        = fs_pc_q;
      pc4_d       = fs_pc_q + 32'd4;
      adel_d      = fs_adel_q;
      dsi_d       = decode_stage_valid && is_j_or_br_DE;
    end else begin
      if (fs_valid_q && !decode_allowin && !buf_valid_q) begin
        inst_buf_d  = inst_sram_rdata;
        buf_valid_d = 1'b1;
      end
      if (decode_allowin && !fs_valid_q) de_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fs_pc_q     <= RESET_PC - 32'd4;
      fs_valid_q  <= 1'b0;
      fs_adel_q   <= 1'b0;
      inst_buf_q  <= '0;
      buf_valid_q <= 1'b0;
      de_valid_q  <= 1'b0;
      inst_q      <= '0;
      pc_q        <= '0;
      pc4_q       <= '0;
      adel_q      <= 1'b0;
      dsi_q       <= 1'b0;
    end else begin
      fs_pc_q     <= fs_pc_d;
      fs_valid_q  <= fs_valid_d;
      fs_adel_q   <= fs_adel_d;
      inst_buf_q  <= inst_buf_d;
      buf_valid_q <= buf_valid_d;
      de_valid_q  <= de_valid_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      adel_q      <= adel_d;
      dsi_q       <= dsi_d;
    end
  end

  assign fe_to_de_valid = de_valid_q;
  assign Inst_IF_DE     = inst_q;
  assign PC_IF_DE       = pc_q;
  assign PC_add_4_IF_DE = pc4_q;
  assign PC_AdEL_IF_DE  = adel_q;
  assign DSI_IF_DE      = dsi_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (transfer && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (fs_valid_q && !decode_allowin && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, stall buffering, branch/DSI, JR address error,
// flush during stall, exception-vs-eret priority and PC+4 wraparound.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        decode_allowin, decode_stage_valid, is_j_or_br_DE;
  logic [1:0]  PCSrc;
  logic        JSrc;
  logic [31:0] J_target_DE, JR_target_DE, Br_target_DE;
  logic        ex_int_handle, eret_handle;
  logic [31:0] epc;
  logic        fe_to_de_valid;
  logic [31:0] Inst_IF_DE, PC_IF_DE, PC_add_4_IF_DE;
  logic        PC_AdEL_IF_DE, DSI_IF_DE;
  logic [31:0] fetch_cnt, stall_cnt;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] cyc = 32'd0;

  fetch_stage #(.RESET_PC(32'hBFC00000), .EXC_VECTOR(32'hBFC00380)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .decode_allowin(decode_allowin), .decode_stage_valid(decode_stage_valid),
    .is_j_or_br_DE(is_j_or_br_DE), .PCSrc(PCSrc), .JSrc(JSrc),
    .J_target_DE(J_target_DE), .JR_target_DE(JR_target_DE), .Br_target_DE(Br_target_DE),
    .ex_int_handle(ex_int_handle), .eret_handle(eret_handle), .epc(epc),
    .fe_to_de_valid(fe_to_de_valid), .Inst_IF_DE(Inst_IF_DE), .PC_IF_DE(PC_IF_DE),
    .PC_add_4_IF_DE(PC_add_4_IF_DE), .PC_AdEL_IF_DE(PC_AdEL_IF_DE), .DSI_IF_DE(DSI_IF_DE),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h13579BDF;
  endfunction

  // SRAM model: one-cycle latency; junk that changes every cycle when not enabled.
  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    inst_sram_rdata <= inst_sram_en ? mem(inst_sram_addr) : (32'hD0000000 | cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; decode_allowin = 1'b1; decode_stage_valid = 1'b0; is_j_or_br_DE = 1'b0;
    PCSrc = 2'b00; JSrc = 1'b0; J_target_DE = '0; JR_target_DE = '0; Br_target_DE = '0;
    ex_int_handle = 1'b0; eret_handle = 1'b0; epc = '0;
    step(); step();
    checks++; if (fe_to_de_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", fe_to_de_valid); end
    checks++; if (PC_IF_DE !== 32'h0 || Inst_IF_DE !== 32'h0) begin failures++; $display("FAIL reset_regs pc=%h inst=%h exp=0", PC_IF_DE, Inst_IF_DE); end
    checks++; if (inst_sram_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", inst_sram_en); end
    rst = 1'b0;
    #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC00000) begin failures++; $display("FAIL first_req en=%b addr=%h exp=1 bfc00000", inst_sram_en, inst_sram_addr); end
    step();
    checks++; if (inst_sram_addr !== 32'hBFC00004 || fe_to_de_valid !== 1'b0) begin failures++; $display("FAIL second_req addr=%h v=%b exp=bfc00004 0", inst_sram_addr, fe_to_de_valid); end
    step();
    checks++; if (inst_sram_addr !== 32'hBFC00008) begin failures++; $display("FAIL third_req addr=%h exp=bfc00008", inst_sram_addr); end
    checks++; if (fe_to_de_valid !== 1'b1 || PC_IF_DE !== 32'hBFC00000 || PC_add_4_IF_DE !== 32'hBFC00004)
      begin failures++; $display("FAIL first_deliver v=%b pc=%h pc4=%h exp=1 bfc00000 bfc00004", fe_to_de_valid, PC_IF_DE, PC_add_4_IF_DE); end
    checks++; if (Inst_IF_DE !== mem(32'hBFC00000)) begin failures++; $display("FAIL first_inst got=%h exp=%h", Inst_IF_DE, mem(32'hBFC00000)); end
  endtask

  task automatic test_stall();
    step();
    checks++; if (PC_IF_DE !== 32'hBFC00004) begin failures++; $display("FAIL pre_stall_pc got=%h exp=bfc00004", PC_IF_DE); end
    decode_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (inst_sram_en !== 1'b0) begin failures++; $display("FAIL stall_en cycle=%0d got=%b exp=0", i, inst_sram_en); end
      step();
    end
    checks++; if (PC_IF_DE !== 32'hBFC00004 || fe_to_de_valid !== 1'b1) begin failures++; $display("FAIL stall_hold pc=%h v=%b exp=bfc00004 1", PC_IF_DE, fe_to_de_valid); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
`else
    checks++; if (stall_cnt !== 32'd0 || fetch_cnt !== 32'd0) begin failures++; $display("FAIL cnt_off stall=%0d fetch=%0d exp=0 0", stall_cnt, fetch_cnt); end
`endif
    decode_allowin = 1'b1;
    #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0000C) begin failures++; $display("FAIL resume_req en=%b addr=%h exp=1 bfc0000c", inst_sram_en, inst_sram_addr); end
    step();
    checks++; if (PC_IF_DE !== 32'hBFC00008 || Inst_IF_DE !== mem(32'hBFC00008))
      begin failures++; $display("FAIL stall_buf pc=%h inst=%h exp=bfc00008 %h", PC_IF_DE, Inst_IF_DE, mem(32'hBFC00008)); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd3) begin failures++; $display("FAIL fetch_cnt got=%0d exp=3", fetch_cnt); end
`endif
  endtask

  task automatic test_branch();
    step(); step();
    checks++; if (PC_IF_DE !== 32'hBFC00010) begin failures++; $display("FAIL br_in_de pc=%h exp=bfc00010", PC_IF_DE); end
    decode_stage_valid = 1'b1; is_j_or_br_DE = 1'b1; PCSrc = 2'b01; Br_target_DE = 32'hBFC00100;
    #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC00100) begin failures++; $display("FAIL br_req en=%b addr=%h exp=1 bfc00100", inst_sram_en, inst_sram_addr); end
    step();
    PCSrc = 2'b00; is_j_or_br_DE = 1'b0;
    checks++; if (PC_IF_DE !== 32'hBFC00014 || DSI_IF_DE !== 1'b1 || Inst_IF_DE !== mem(32'hBFC00014))
      begin failures++; $display("FAIL delay_slot pc=%h dsi=%b inst=%h exp=bfc00014 1 %h", PC_IF_DE, DSI_IF_DE, Inst_IF_DE, mem(32'hBFC00014)); end
  endtask

  task automatic test_jr_adel();
    is_j_or_br_DE = 1'b1; PCSrc = 2'b10; JSrc = 1'b1; JR_target_DE = 32'h80000002; J_target_DE = 32'hBFC00200;
    #1;
    checks++; if (inst_sram_en !== 1'b0 || inst_sram_addr !== 32'h80000002) begin failures++; $display("FAIL jr_req en=%b addr=%h exp=0 80000002", inst_sram_en, inst_sram_addr); end
    step();
    PCSrc = 2'b00; JSrc = 1'b0; is_j_or_br_DE = 1'b0; decode_stage_valid = 1'b0;
    checks++; if (PC_IF_DE !== 32'hBFC00100 || DSI_IF_DE !== 1'b1) begin failures++; $display("FAIL jr_slot pc=%h dsi=%b exp=bfc00100 1", PC_IF_DE, DSI_IF_DE); end
    step();
    checks++; if (PC_IF_DE !== 32'h80000002 || PC_AdEL_IF_DE !== 1'b1 || Inst_IF_DE !== 32'h0 || DSI_IF_DE !== 1'b0)
      begin failures++; $display("FAIL adel pc=%h adel=%b inst=%h dsi=%b exp=80000002 1 0 0", PC_IF_DE, PC_AdEL_IF_DE, Inst_IF_DE, DSI_IF_DE); end
  endtask

  task automatic test_exc_stall();
    decode_allowin = 1'b0;
    step();
    ex_int_handle = 1'b1;
    #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC00380) begin failures++; $display("FAIL exc_req en=%b addr=%h exp=1 bfc00380", inst_sram_en, inst_sram_addr); end
    step();
    ex_int_handle = 1'b0;
    checks++; if (fe_to_de_valid !== 1'b0) begin failures++; $display("FAIL exc_flush v=%b exp=0", fe_to_de_valid); end
    decode_allowin = 1'b1;
    #1;
    checks++; if (inst_sram_addr !== 32'hBFC00384) begin failures++; $display("FAIL exc_next addr=%h exp=bfc00384", inst_sram_addr); end
    step();
    checks++; if (fe_to_de_valid !== 1'b1 || PC_IF_DE !== 32'hBFC00380 || Inst_IF_DE !== mem(32'hBFC00380) || PC_AdEL_IF_DE !== 1'b0)
      begin failures++; $display("FAIL exc_deliver v=%b pc=%h inst=%h adel=%b exp=1 bfc00380 %h 0", fe_to_de_valid, PC_IF_DE, Inst_IF_DE, PC_AdEL_IF_DE, mem(32'hBFC00380)); end
  endtask

  task automatic test_exc_eret();
    ex_int_handle = 1'b1; eret_handle = 1'b1; epc = 32'h80001000;
    #1;
    checks++; if (inst_sram_addr !== 32'hBFC00380) begin failures++; $display("FAIL both_req addr=%h exp=bfc00380", inst_sram_addr); end
    step();
    ex_int_handle = 1'b0;
    checks++; if (fe_to_de_valid !== 1'b0) begin failures++; $display("FAIL both_flush v=%b exp=0", fe_to_de_valid); end
    #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h80001000) begin failures++; $display("FAIL eret_req en=%b addr=%h exp=1 80001000", inst_sram_en, inst_sram_addr); end
    step();
    eret_handle = 1'b0;
    step();
    checks++; if (fe_to_de_valid !== 1'b1 || PC_IF_DE !== 32'h80001000 || Inst_IF_DE !== mem(32'h80001000))
      begin failures++; $display("FAIL eret_deliver v=%b pc=%h inst=%h exp=1 80001000 %h", fe_to_de_valid, PC_IF_DE, Inst_IF_DE, mem(32'h80001000)); end
  endtask

  task automatic test_wrap();
    eret_handle = 1'b1; epc = 32'hFFFFFFFC;
    step();
    eret_handle = 1'b0;
    #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h0) begin failures++; $display("FAIL wrap_req en=%b addr=%h exp=1 0", inst_sram_en, inst_sram_addr); end
    step();
    checks++; if (PC_IF_DE !== 32'hFFFFFFFC || PC_add_4_IF_DE !== 32'h0) begin failures++; $display("FAIL wrap_pc4 pc=%h pc4=%h exp=fffffffc 0", PC_IF_DE, PC_add_4_IF_DE); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_jr_adel();
    test_exc_stall();
    test_exc_eret();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
